// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue feeding the LSU. Ops issue one cycle after the head becomes eligible; load_stall/full back-pressure.
// Define MEM_ISSUE_CDB_BYPASS_EN to let the head issue on the same edge as the CDB broadcast that completes it.
module mem_issue_queue #(
  parameter int QUEUE_SIZE = 8,
  parameter int PTR_W      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        disp_valid,
  input  logic        disp_is_ld,
  input  logic        disp_base_rdy,
  input  logic [15:0] disp_base,
  input  logic        disp_data_rdy,
  input  logic [15:0] disp_data,
  input  logic [15:0] disp_offset,
  input  logic [5:0]  disp_ROB,
  output logic        full,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_ROB,
  input  logic [15:0] cdb_data,
  input  logic        load_stall,
  output logic        is_ld,
  output logic [15:0] data,
  output logic [15:0] location,
  output logic [5:0]  ROBloc,
  output logic        input_valid
);

  logic [QUEUE_SIZE-1:0] vld_q;
  logic [QUEUE_SIZE-1:0] ld_q;
  logic [QUEUE_SIZE-1:0] brdy_q;
  logic [QUEUE_SIZE-1:0] drdy_q;
  logic [15:0]           base_q [QUEUE_SIZE];
  logic [15:0]           dat_q  [QUEUE_SIZE];
  logic [15:0]           off_q  [QUEUE_SIZE];
  logic [5:0]            rob_q  [QUEUE_SIZE];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic        enq;
  logic        issue;
  logic        disp_base_hit;
  logic        disp_data_hit;
  logic        h_base_byp;
  logic        h_data_byp;
  logic        h_base_ok;
  logic        h_data_ok;
  logic        eligible;
  logic [15:0] h_base_val;
  logic [15:0] h_data_val;

  assign full = (count_q == (PTR_W+1)'(QUEUE_SIZE));
  assign enq  = disp_valid && !full && !flush;

  // A tag broadcast in the dispatch cycle would otherwise be missed by the new entry.
  assign disp_base_hit = !disp_base_rdy && cdb_valid && (cdb_ROB == disp_base[5:0]);
  assign disp_data_hit = !disp_data_rdy && cdb_valid && (cdb_ROB == disp_data[5:0]);

`ifdef MEM_ISSUE_CDB_BYPASS_EN
  assign h_base_byp = !brdy_q[head_q] && cdb_valid && (cdb_ROB == base_q[head_q][5:0]);
  assign h_data_byp = !ld_q[head_q] && !drdy_q[head_q] && cdb_valid &&
                      (cdb_ROB == dat_q[head_q][5:0]);
`else
  assign h_base_byp = 1'b0;
  assign h_data_byp = 1'b0;
`endif

  always_comb begin
    h_base_ok  = brdy_q[head_q] || h_base_byp;
    h_data_ok  = ld_q[head_q] || drdy_q[head_q] || h_data_byp;
    h_base_val = brdy_q[head_q] ? base_q[head_q] : cdb_data;
    h_data_val = drdy_q[head_q] ? dat_q[head_q] : cdb_data;
    eligible   = vld_q[head_q] && h_base_ok && h_data_ok;
    issue      = eligible && !load_stall && !flush;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) head_d = head_q + PTR_W'(1);
      if (enq)   tail_d = tail_q + PTR_W'(1);
      if (enq && !issue)      count_d = count_q + (PTR_W+1)'(1);
      else if (issue && !enq) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      ld_q   <= '0;
      brdy_q <= '0;
      drdy_q <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        base_q[i] <= '0;
        dat_q[i]  <= '0;
        off_q[i]  <= '0;
        rob_q[i]  <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (vld_q[i] && cdb_valid) begin
          if (!brdy_q[i] && (cdb_ROB == base_q[i][5:0])) begin
            brdy_q[i] <= 1'b1;
            base_q[i] <= cdb_data;
          end
          if (!drdy_q[i] && (cdb_ROB == dat_q[i][5:0])) begin
            drdy_q[i] <= 1'b1;
            dat_q[i]  <= cdb_data;
          end
        end
      end
      if (issue) vld_q[head_q] <= 1'b0;
      // Tail slot is never valid when enq fires, so this cannot collide with wakeup.
      if (enq) begin
        vld_q[tail_q]  <= 1'b1;
        ld_q[tail_q]   <= disp_is_ld;
        brdy_q[tail_q] <= disp_base_rdy || disp_base_hit;
        base_q[tail_q] <= disp_base_hit ? cdb_data : disp_base;
        drdy_q[tail_q] <= disp_data_rdy || disp_data_hit;
        dat_q[tail_q]  <= disp_data_hit ? cdb_data : disp_data;
        off_q[tail_q]  <= disp_offset;
        rob_q[tail_q]  <= disp_ROB;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_valid <= 1'b0;
      is_ld       <= 1'b0;
      data        <= '0;
      location    <= '0;
      ROBloc      <= '0;
    end else if (issue) begin
      input_valid <= 1'b1;
      is_ld       <= ld_q[head_q];
      data        <= ld_q[head_q] ? 16'h0000 : h_data_val;
      location    <= h_base_val + off_q[head_q];
      ROBloc      <= rob_q[head_q];
    end else begin
      input_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed scenarios plus a randomized run scored against a queue-level reference model.
module tb_mem_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        disp_valid, disp_is_ld, disp_base_rdy, disp_data_rdy;
  logic [15:0] disp_base, disp_data, disp_offset;
  logic [5:0]  disp_ROB;
  logic        full;
  logic        cdb_valid;
  logic [5:0]  cdb_ROB;
  logic [15:0] cdb_data;
  logic        load_stall;
  logic        is_ld;
  logic [15:0] data, location;
  logic [5:0]  ROBloc;
  logic        input_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_issue_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_is_ld(disp_is_ld),
    .disp_base_rdy(disp_base_rdy), .disp_base(disp_base),
    .disp_data_rdy(disp_data_rdy), .disp_data(disp_data),
    .disp_offset(disp_offset), .disp_ROB(disp_ROB), .full(full),
    .cdb_valid(cdb_valid), .cdb_ROB(cdb_ROB), .cdb_data(cdb_data),
    .load_stall(load_stall), .is_ld(is_ld), .data(data),
    .location(location), .ROBloc(ROBloc), .input_valid(input_valid)
  );

  typedef struct {
    bit          ld;
    bit          br;
    logic [15:0] b;
    bit          dr;
    logic [15:0] d;
    logic [15:0] off;
    logic [5:0]  rob;
  } ent_t;

  ent_t        mq[$];
  bit          e_iv, e_ld, e_full;
  logic [15:0] e_data, e_loc;
  logic [5:0]  e_rob;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 0; disp_is_ld = 0; disp_base_rdy = 0; disp_data_rdy = 0;
    disp_base = 0; disp_data = 0; disp_offset = 0; disp_ROB = 0;
    cdb_valid = 0; cdb_ROB = 0; cdb_data = 0;
  endtask

  task automatic disp(input bit ld, input bit br, input logic [15:0] b, input bit dr,
                      input logic [15:0] d, input logic [15:0] off, input logic [5:0] rob);
    disp_valid = 1; disp_is_ld = ld; disp_base_rdy = br; disp_base = b;
    disp_data_rdy = dr; disp_data = d; disp_offset = off; disp_ROB = rob;
  endtask

  // Queue-level view of one clock edge, evaluated on the inputs presented before it.
  task automatic model_edge();
    int   pre;
    ent_t h, n;
    bit   bok, dok;
    logic [15:0] bv, dv;
    e_iv = 0;
    if (flush) begin
      mq.delete();
    end else begin
      pre = mq.size();
      if (pre > 0) begin
        h = mq[0];
        bok = h.br; bv = h.b; dok = h.ld || h.dr; dv = h.d;
`ifdef MEM_ISSUE_CDB_BYPASS_EN
        if (!h.br && cdb_valid && cdb_ROB == h.b[5:0]) begin bok = 1; bv = cdb_data; end
        if (!h.ld && !h.dr && cdb_valid && cdb_ROB == h.d[5:0]) begin dok = 1; dv = cdb_data; end
`endif
        if (bok && dok && !load_stall) begin
          void'(mq.pop_front());
          e_iv = 1; e_ld = h.ld; e_rob = h.rob;
          e_loc = bv + h.off;
          e_data = h.ld ? 16'h0 : dv;
        end
      end
      foreach (mq[i]) begin
        if (cdb_valid && !mq[i].br && cdb_ROB == mq[i].b[5:0]) begin mq[i].br = 1; mq[i].b = cdb_data; end
        if (cdb_valid && !mq[i].dr && cdb_ROB == mq[i].d[5:0]) begin mq[i].dr = 1; mq[i].d = cdb_data; end
      end
      if (disp_valid && pre < 8) begin
        n.ld = disp_is_ld; n.off = disp_offset; n.rob = disp_ROB;
        n.br = disp_base_rdy; n.b = disp_base; n.dr = disp_data_rdy; n.d = disp_data;
        if (!n.br && cdb_valid && cdb_ROB == n.b[5:0]) begin n.br = 1; n.b = cdb_data; end
        if (!n.dr && cdb_valid && cdb_ROB == n.d[5:0]) begin n.dr = 1; n.d = cdb_data; end
        mq.push_back(n);
      end
    end
    e_full = (mq.size() == 8);
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; load_stall = 0;
    idle();
    #12;
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL reset_iv: got %b expected 0", input_valid); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full); end
    n_cmp++; if ({is_ld, data, location, ROBloc} !== 39'h0) begin n_bad++;
      $display("FAIL reset_outs: got ld=%b data=%h loc=%h rob=%0d expected all 0", is_ld, data, location, ROBloc); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_ready_load();
    disp(1, 1, 16'h0100, 0, 16'h0, 16'h0004, 6'd5);
    tick();
    idle();
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL ld_early: got iv=%b expected 0", input_valid); end
    tick();
    n_cmp++; if (input_valid !== 1'b1) begin n_bad++; $display("FAIL ld_iv: got %b expected 1", input_valid); end
    n_cmp++; if ({is_ld, location, ROBloc, data} !== {1'b1, 16'h0104, 6'd5, 16'h0}) begin n_bad++;
      $display("FAIL ld_outs: got ld=%b loc=%h rob=%0d data=%h expected 1/0104/5/0000", is_ld, location, ROBloc, data); end
    tick();
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL ld_once: got iv=%b expected 0", input_valid); end
  endtask

  task automatic test_cdb_store();
    disp(0, 1, 16'h0010, 0, 16'd9, 16'h0002, 6'd7);
    tick();
    idle();
    tick();
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL st_wait: got iv=%b expected 0", input_valid); end
    cdb_valid = 1; cdb_ROB = 6'd9; cdb_data = 16'hBEEF;
    tick();
    idle();
`ifndef MEM_ISSUE_CDB_BYPASS_EN
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL st_nobyp: got iv=%b expected 0", input_valid); end
    tick();
`endif
    n_cmp++; if (input_valid !== 1'b1) begin n_bad++; $display("FAIL st_iv: got %b expected 1", input_valid); end
    n_cmp++; if ({is_ld, data, location, ROBloc} !== {1'b0, 16'hBEEF, 16'h0012, 6'd7}) begin n_bad++;
      $display("FAIL st_outs: got ld=%b data=%h loc=%h rob=%0d expected 0/beef/0012/7", is_ld, data, location, ROBloc); end
    tick();
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL st_once: got iv=%b expected 0", input_valid); end
  endtask

  task automatic test_ordering();
    disp(1, 0, 16'd3, 0, 16'h0, 16'h0020, 6'd10);
    tick();
    disp(0, 1, 16'h0040, 1, 16'h1234, 16'h0000, 6'd11);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL ord_block%0d: got iv=%b expected 0", i, input_valid); end
    end
    cdb_valid = 1; cdb_ROB = 6'd3; cdb_data = 16'h1000;
    tick();
    idle();
`ifndef MEM_ISSUE_CDB_BYPASS_EN
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL ord_nobyp: got iv=%b expected 0", input_valid); end
    tick();
`endif
    n_cmp++; if ({input_valid, is_ld, location, ROBloc} !== {1'b1, 1'b1, 16'h1020, 6'd10}) begin n_bad++;
      $display("FAIL ord_load: got iv=%b ld=%b loc=%h rob=%0d expected 1/1/1020/10", input_valid, is_ld, location, ROBloc); end
    tick();
    n_cmp++; if ({input_valid, is_ld, data, location, ROBloc} !== {1'b1, 1'b0, 16'h1234, 16'h0040, 6'd11}) begin n_bad++;
      $display("FAIL ord_store: got iv=%b ld=%b data=%h loc=%h rob=%0d expected 1/0/1234/0040/11", input_valid, is_ld, data, location, ROBloc); end
    tick();
  endtask

  task automatic test_fill_wrap();
    load_stall = 1;
    for (int i = 0; i < 8; i++) begin
      disp(i[0], 1, 16'(i * 256), 1, 16'(i + 16'hA000), 16'(i), 6'(20 + i));
      tick();
      n_cmp++; if (full !== (i == 7)) begin n_bad++; $display("FAIL fill_full%0d: got %b expected %b", i, full, i == 7); end
    end
    disp(1, 1, 16'h7777, 1, 16'h0, 16'h0, 6'd63);
    tick();
    idle();
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_9th: got full=%b expected 1", full); end
    load_stall = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++; if ({input_valid, ROBloc, location} !== {1'b1, 6'(20 + i), 16'(i * 256 + i)}) begin n_bad++;
        $display("FAIL drain%0d: got iv=%b rob=%0d loc=%h expected 1/%0d/%h", i, input_valid, ROBloc, location, 20 + i, 16'(i * 256 + i)); end
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL drain_full%0d: got %b expected 0", i, full); end
    end
    tick();
    n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL drain_end: got iv=%b rob=%0d expected 0", input_valid, ROBloc); end
  endtask

  task automatic test_addr_wrap();
    disp(1, 1, 16'hFFFE, 0, 16'h0, 16'h0005, 6'd1);
    tick();
    idle();
    tick();
    n_cmp++; if ({input_valid, location} !== {1'b1, 16'h0003}) begin n_bad++;
      $display("FAIL addr_wrap: got iv=%b loc=%h expected 1/0003", input_valid, location); end
    tick();
  endtask

  task automatic test_flush();
    load_stall = 1;
    for (int i = 0; i < 4; i++) begin
      disp(1, 1, 16'h0300, 0, 16'h0, 16'(i), 6'(40 + i));
      tick();
    end
    load_stall = 0;
    flush = 1;
    disp(1, 1, 16'h0500, 0, 16'h0, 16'h0, 6'd44);
    tick();
    flush = 0;
    idle();
    n_cmp++; if ({input_valid, full} !== 2'b00) begin n_bad++; $display("FAIL flush_now: got iv=%b full=%b expected 0/0", input_valid, full); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (input_valid !== 1'b0) begin n_bad++; $display("FAIL flush_quiet%0d: got iv=%b rob=%0d expected 0", i, input_valid, ROBloc); end
    end
    disp(1, 1, 16'h0200, 0, 16'h0, 16'h0, 6'd33);
    tick();
    idle();
    tick();
    n_cmp++; if ({input_valid, ROBloc, location} !== {1'b1, 6'd33, 16'h0200}) begin n_bad++;
      $display("FAIL flush_after: got iv=%b rob=%0d loc=%h expected 1/33/0200", input_valid, ROBloc, location); end
    tick();
  endtask

  task automatic test_async_reset();
    disp(1, 1, 16'h0900, 0, 16'h0, 16'h0001, 6'd12);
    tick();
    idle();
    tick();
    n_cmp++; if (input_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got iv=%b expected 1", input_valid); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({input_valid, location, ROBloc, full} !== {1'b0, 16'h0, 6'd0, 1'b0}) begin n_bad++;
      $display("FAIL arst_now: got iv=%b loc=%h rob=%0d full=%b expected all 0", input_valid, location, ROBloc, full); end
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    rst_n = 0;
    idle(); flush = 0; load_stall = 0;
    tick();
    rst_n = 1;
    mq.delete();
    tick();
    for (int c = 0; c < 1500; c++) begin
      disp_valid    = ($urandom_range(0, 99) < 60);
      disp_is_ld    = $urandom_range(0, 1);
      disp_base_rdy = ($urandom_range(0, 99) < 50);
      disp_base     = disp_base_rdy ? 16'($urandom) : {10'($urandom), 6'($urandom_range(0, 7))};
      disp_data_rdy = ($urandom_range(0, 99) < 50);
      disp_data     = disp_data_rdy ? 16'($urandom) : {10'($urandom), 6'($urandom_range(0, 7))};
      disp_offset   = 16'($urandom);
      disp_ROB      = 6'($urandom);
      cdb_valid     = ($urandom_range(0, 99) < 40);
      cdb_ROB       = 6'($urandom_range(0, 7));
      cdb_data      = 16'($urandom);
      load_stall    = ($urandom_range(0, 99) < 25);
      flush         = ($urandom_range(0, 99) < 3);
      model_edge();
      tick();
      n_cmp++; if (input_valid !== e_iv) begin n_bad++; $display("FAIL rnd_iv@%0d: got %b expected %b", c, input_valid, e_iv); end
      if (e_iv) begin
        n_cmp++; if ({is_ld, data, location, ROBloc} !== {e_ld, e_data, e_loc, e_rob}) begin n_bad++;
          $display("FAIL rnd_op@%0d: got ld=%b data=%h loc=%h rob=%0d expected %b/%h/%h/%0d",
                   c, is_ld, data, location, ROBloc, e_ld, e_data, e_loc, e_rob); end
      end
      n_cmp++; if (full !== e_full) begin n_bad++; $display("FAIL rnd_full@%0d: got %b expected %b", c, full, e_full); end
    end
    flush = 0;
    idle();
    load_stall = 0;
  endtask

  initial begin
    test_reset();
    test_ready_load();
    test_cdb_store();
    test_ordering();
    test_fill_wrap();
    test_addr_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
